// File: rtl/mux_pkg.sv
// Shared select type, select constants and one-hot decode for the 4:1 mux.
// Latency: n/a (types and a pure function only).
// Backpressure: none.
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'd0;
    localparam sel_t SEL_D1 = 2'd1;
    localparam sel_t SEL_D2 = 2'd2;
    localparam sel_t SEL_D3 = 2'd3;

    function automatic logic [3:0] onehot4(input sel_t sel);
        logic [3:0] oh;
        oh = 4'b0000;
        case (sel)
            SEL_D0:  oh = 4'b0001;
            SEL_D1:  oh = 4'b0010;
            SEL_D2:  oh = 4'b0100;
            SEL_D3:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux_2to1.sv
// Two-input WIDTH-bit selector; leaf of the 4:1 tree.
// Latency: combinational.
// Backpressure: none.
module mux_2to1 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mux_4to1.sv
// 4:1 data mux with combinational Y plus enable-gated registered Y_q and select one-hot.
// Latency: Y 0 cycles; Y_q / sel_onehot_q 1 cycle after an en=1 edge.
// Backpressure: none; en=0 holds the registered outputs.
module mux_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             S0,
    input  logic             S1,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic [3:0]       sel_onehot_q
);

    sel_t             sel;
    logic [WIDTH-1:0] y_lo;
    logic [WIDTH-1:0] y_hi;

    assign sel = {S1, S0};

    // S0 picks within each pair, S1 picks between the pairs.
    mux_2to1 #(.WIDTH(WIDTH)) u_mux_lo (
        .d0 (D0),
        .d1 (D1),
        .s  (S0),
        .y  (y_lo)
    );

    mux_2to1 #(.WIDTH(WIDTH)) u_mux_hi (
        .d0 (D2),
        .d1 (D3),
        .s  (S0),
        .y  (y_hi)
    );

    mux_2to1 #(.WIDTH(WIDTH)) u_mux_out (
        .d0 (y_lo),
        .d1 (y_hi),
        .s  (S1),
        .y  (Y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q          <= '0;
            sel_onehot_q <= 4'b0000;
        end else if (en) begin
            Y_q          <= Y;
            sel_onehot_q <= onehot4(sel);
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Scoreboarded bench for mux_4to1 at WIDTH=1 and WIDTH=8 sharing select/enable/reset.
module tb_mux_4to1;

    typedef struct {
        logic       y1;
        logic [7:0] y8;
        logic [3:0] oh;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       s0;
    logic       s1;
    logic       d1 [4];
    logic [7:0] d8 [4];
    logic       y1, y1_q;
    logic [7:0] y8, y8_q;
    logic [3:0] oh1, oh8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last;
    exp_t e;

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en),
        .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]),
        .S0(s0), .S1(s1),
        .Y(y1), .Y_q(y1_q), .sel_onehot_q(oh1)
    );

    mux_4to1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en),
        .D0(d8[0]), .D1(d8[1]), .D2(d8[2]), .D3(d8[3]),
        .S0(s0), .S1(s1),
        .Y(y8), .Y_q(y8_q), .sel_onehot_q(oh8)
    );

    // w packs the wide inputs as {D3, D2, D1, D0}.
    task automatic drive(input logic [1:0] sel, input logic [3:0] b1, input logic [31:0] w);
        {s1, s0} = sel;
        for (int i = 0; i < 4; i++) begin
            d1[i] = b1[i];
            d8[i] = w[8*i +: 8];
        end
    endtask

    // Expected registered result if the coming edge captures; also remembered for hold checks.
    task automatic push_capture();
        logic [1:0] sel;
        exp_t x;
        sel  = {s1, s0};
        x.y1 = d1[sel];
        x.y8 = d8[sel];
        x.oh = 4'b0001 << sel;
        last = x;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        logic [1:0] sel;
        @(negedge clk);
        en = 1'b1;
        sel = 2'($urandom_range(0, 3));
        drive(sel, 4'($urandom), $urandom);
        rst = 1'b1;
        #1;
        checks += 4;
        if (y1_q !== 1'b0)    begin errors++; $display("FAIL reset_y1_q got %h want 0", y1_q); end
        if (y8_q !== 8'h00)   begin errors++; $display("FAIL reset_y8_q got %h want 00", y8_q); end
        if (oh1 !== 4'b0000)  begin errors++; $display("FAIL reset_oh1 got %b want 0000", oh1); end
        if (oh8 !== 4'b0000)  begin errors++; $display("FAIL reset_oh8 got %b want 0000", oh8); end
        checks += 2;
        if (y1 !== d1[sel]) begin errors++; $display("FAIL reset_y1_tracks got %h want %h", y1, d1[sel]); end
        if (y8 !== d8[sel]) begin errors++; $display("FAIL reset_y8_tracks got %h want %h", y8, d8[sel]); end
        @(posedge clk);
        #1;
        checks++;
        if (y8_q !== 8'h00 || oh8 !== 4'b0000) begin
            errors++; $display("FAIL reset_overrides_en got %h/%b want 00/0000", y8_q, oh8);
        end
        @(negedge clk);
        rst = 1'b0;
        en = 1'b0;
        last = '{1'b0, 8'h00, 4'b0000};
    endtask

    task automatic test_select_sweep();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = 1'b1;
            drive(2'(i), 4'b0001 << i, $urandom);
            #1;
            checks += 2;
            if (y1 !== 1'b1)  begin errors++; $display("FAIL sweep_y1 sel=%0d got %h want 1", i, y1); end
            if (y8 !== d8[i]) begin errors++; $display("FAIL sweep_y8 sel=%0d got %h want %h", i, y8, d8[i]); end
            push_capture();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks += 4;
            if (y1_q !== e.y1) begin errors++; $display("FAIL sweep_y1_q sel=%0d got %h want %h", i, y1_q, e.y1); end
            if (y8_q !== e.y8) begin errors++; $display("FAIL sweep_y8_q sel=%0d got %h want %h", i, y8_q, e.y8); end
            if (oh1 !== e.oh)  begin errors++; $display("FAIL sweep_oh1 sel=%0d got %b want %b", i, oh1, e.oh); end
            if (oh8 !== e.oh)  begin errors++; $display("FAIL sweep_oh8 sel=%0d got %b want %b", i, oh8, e.oh); end
        end
    endtask

    task automatic test_isolation();
        logic [1:0] sels [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
        logic [3:0] vals [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
        logic       want [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(sels[i], vals[i], 32'h0);
            #1;
            checks++;
            if (y1 !== want[i]) begin
                errors++; $display("FAIL isolation case=%0d got %h want %h", i, y1, want[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        en = 1'b1;
        drive(2'd3, 4'b1000, $urandom);
        push_capture();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks += 2;
        if (y1_q !== e.y1 || oh1 !== e.oh) begin
            errors++; $display("FAIL hold_capture got %h/%b want %h/%b", y1_q, oh1, e.y1, e.oh);
        end
        if (y8_q !== e.y8) begin errors++; $display("FAIL hold_capture_y8 got %h want %h", y8_q, e.y8); end
        @(negedge clk);
        en = 1'b0;
        drive(2'd0, 4'b0000, $urandom);
        #1;
        checks++;
        if (y1 !== 1'b0) begin errors++; $display("FAIL hold_y_immediate got %h want 0", y1); end
        for (int k = 0; k < 3; k++) begin
            sb.push_back(last);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks += 3;
            if (y1_q !== 1'b1 || y1_q !== e.y1) begin errors++; $display("FAIL hold_y1_q edge=%0d got %h want 1", k, y1_q); end
            if (oh1 !== 4'b1000)                begin errors++; $display("FAIL hold_oh1 edge=%0d got %b want 1000", k, oh1); end
            if (y8_q !== e.y8)                  begin errors++; $display("FAIL hold_y8_q edge=%0d got %h want %h", k, y8_q, e.y8); end
        end
    endtask

    task automatic test_wide();
        logic [7:0] want [4] = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = 1'b1;
            drive(2'(i), 4'($urandom), 32'h00FF_5AA5);
            #1;
            checks++;
            if (y8 !== want[i]) begin errors++; $display("FAIL wide_y sel=%0d got %h want %h", i, y8, want[i]); end
            push_capture();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks += 2;
            if (y8_q !== want[i] || y8_q !== e.y8) begin errors++; $display("FAIL wide_y_q sel=%0d got %h want %h", i, y8_q, want[i]); end
            if (oh8 !== e.oh) begin errors++; $display("FAIL wide_oh sel=%0d got %b want %b", i, oh8, e.oh); end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b1;
            drive(2'($urandom_range(0, 3)), 4'($urandom), $urandom);
            push_capture();
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (y8_q !== e.y8 || oh8 !== e.oh || y1_q !== e.y1) begin
                errors++; $display("FAIL stream cyc=%0d got %h/%b want %h/%b", i, y8_q, oh8, e.y8, e.oh);
            end
        end
        // Short pulse between edges: clears at once, next edge captures normally.
        @(negedge clk);
        drive(2'd2, 4'b0100, 32'h0033_2211);
        rst = 1'b1;
        #1;
        checks++;
        if (y8_q !== 8'h00 || oh8 !== 4'b0000 || y1_q !== 1'b0) begin
            errors++; $display("FAIL midreset_clear got %h/%b want 00/0000", y8_q, oh8);
        end
        #1;
        rst = 1'b0;
        push_capture();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (y8_q !== 8'h33 || y8_q !== e.y8 || oh8 !== 4'b0100 || y1_q !== 1'b1) begin
            errors++; $display("FAIL midreset_recapture got %h/%b want 33/0100", y8_q, oh8);
        end
        // Reset held across an edge: that capture is lost.
        @(negedge clk);
        drive(2'd1, 4'b0010, 32'h4444_7744);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y8_q !== 8'h00 || oh8 !== 4'b0000) begin
            errors++; $display("FAIL midreset_lost got %h/%b want 00/0000", y8_q, oh8);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(2'd3, 4'b1000, 32'h9900_0000);
        push_capture();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (y8_q !== e.y8 || oh8 !== e.oh || y1_q !== e.y1) begin
            errors++; $display("FAIL midreset_first_edge got %h/%b want %h/%b", y8_q, oh8, e.y8, e.oh);
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        drive(2'd0, 4'b0000, 32'h0);
        test_reset();
        test_select_sweep();
        test_isolation();
        test_enable_hold();
        test_wide();
        test_reset_midstream();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain left %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_4to1.md
# mux_4to1

Parameterised 4-to-1 data multiplexer with a combinational output and a registered copy of that output. Two select bits choose one of four data inputs. The block is a leaf datapath primitive. It is used wherever a downstream stage needs either same-cycle selection or a cleanly registered selection result.

## Interface
Parameters:
- WIDTH, default 1: bit width of each data input and of both outputs.

Ports:
- clk, input, 1: single clock; the rising edge updates all registered state.
- rst, input, 1: reset, asynchronous and active-high.
- en, input, 1: capture enable for the registered outputs.
- D0, input, WIDTH: data input selected when {S1,S0} = 2'b00.
- D1, input, WIDTH: data input selected when {S1,S0} = 2'b01.
- D2, input, WIDTH: data input selected when {S1,S0} = 2'b10.
- D3, input, WIDTH: data input selected when {S1,S0} = 2'b11.
- S0, input, 1: select LSB.
- S1, input, 1: select MSB.
- Y, output, WIDTH: combinational selected data.
- Y_q, output, WIDTH: registered Y.
- sel_onehot_q, output, 4: registered one-hot decode of {S1,S0}; bit n set means Dn is selected.

## Operation
- Select encoding: sel = {S1,S0}, so S1 is the MSB.
  - 00 selects D0, 01 selects D1, 10 selects D2, 11 selects D3.
- Y = D[sel], purely combinational. Y has no dependency on clk, rst or en.
- On a rising clk edge with en = 1:
  - Y_q <= Y.
  - sel_onehot_q <= 4'b0001 << sel.
- On a rising clk edge with en = 0: Y_q and sel_onehot_q hold their values.
- Unselected inputs have no effect on any output.
  - Example: all Dn = 1 with sel = 01 gives Y = D1.
- X/Z on S0 or S1 is not qualified. Y may go X; no other behaviour is required.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Y: zero-cycle latency, settles within the same delta/cycle as its inputs.
- Y_q and sel_onehot_q: one-cycle latency from inputs sampled at a clk edge with en = 1.
- Reset values: Y_q = 0 (all WIDTH bits) and sel_onehot_q = 4'b0000. These are applied immediately on rst assertion, independent of clk.
- Y is not reset. It follows its inputs even while rst = 1.
- rst = 1 overrides en. While rst is held, no captures occur.
- On the first rising edge after rst deasserts, a capture occurs if en = 1.
- If en and inputs change together at an edge, the pre-edge sampled values are used (standard flop semantics).
- Reset asserted mid-operation clears the registered outputs asynchronously. Any capture that would have happened at that edge is lost.

## Structure
- Shared package mux_pkg holds:
  - typedef sel_t, a 2-bit select type.
  - Constants SEL_D0 = 2'd0, SEL_D1 = 2'd1, SEL_D2 = 2'd2, SEL_D3 = 2'd3.
  - Function onehot4(sel_t) returning the 4-bit one-hot decode.
- Sub-module mux_2to1 (WIDTH-parameterised) is instantiated three times as a tree:
  - Stage 1: D0/D1 selected by S0, and D2/D3 selected by S0.
  - Stage 2: the two stage-1 results selected by S1.
- Output register: one always block, asynchronous active-high reset, enable-gated.

## Test plan
- Reset: assert rst with random inputs and no clock edge -> Y_q = 0 and sel_onehot_q = 0000 immediately. Y tracks its inputs during reset.
- Select sweep (WIDTH = 1): for each sel, set only the selected input to 1 and the rest to 0:
  - D0 = 1, sel 00 -> Y = 1.
  - D1 = 1, sel 01 -> Y = 1.
  - D2 = 1, sel 10 -> Y = 1.
  - D3 = 1, sel 11 -> Y = 1.
  - After one edge with en = 1, Y_q = 1 and sel_onehot_q = 0001, 0010, 0100, 1000 respectively.
- Isolation: set all Dn = 0 except a non-selected input driven to 1 -> Y = 0.
  - Repeat with all Dn = 1 and sel 01, 10 and 11 -> Y = 1 in each case.
- Enable hold: capture sel 11 with D3 = 1, then set en = 0 and change to sel 00 with D0 = 0 -> Y = 0 immediately. Y_q stays 1 and sel_onehot_q stays 1000 across 3 edges.
- Wide data (WIDTH = 8): D0 = 8'hA5, D1 = 8'h5A, D2 = 8'hFF, D3 = 8'h00, sweep sel -> Y = A5, 5A, FF, 00 in turn. Y_q follows one cycle later.
- Async reset mid-stream: while capturing every cycle, pulse rst between edges -> registered outputs clear at once. The first edge after release with en = 1 captures current Y.
